alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Multi-cycle issue/capture front end for the execute stage's ALU. Accepts one operation per valid/ready handshake, maps it to the ALU's 4-bit control code, and drives the ALU operand and control inputs. It holds those inputs stable for the operation's latency, captures the ALU result, and presents it on a valid/ready response port. Sits between the multi-cycle control unit and the combinational ALU.

## Interface
- MUL_CYCLES, 3: number of cycles ALU inputs are held for MUL before the result is captured; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5–7 illegal.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- alu_a  out  32  to ALU reg_a.
- alu_b  out  32  to ALU reg_b.
- alu_ctrl  out  4  to ALU control: ADD 0001, SUB 0010, AND 0011, OR 0100, MUL 0101, idle/illegal 0000.
- alu_result  in  32  from ALU result.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  32  captured result.
- rsp_err  out  1  error flag for this response.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - req_ready=1.
  - On req_valid: latch req_a/req_b into alu_a/alu_b, latch the mapped control code, load the down-counter with 1 (non-MUL) or MUL_CYCLES (MUL), set a pending-err bit if the op is illegal, then go to EXEC.
- EXEC
  - req_ready=0. alu_a, alu_b and alu_ctrl are held constant for the whole state.
  - Counter decrements each cycle.
  - In the cycle where counter==1: capture alu_result into rsp_data and pending-err into rsp_err, then go to RESP.
- RESP
  - rsp_valid=1. rsp_data and rsp_err are stable until the handshake.
  - On rsp_ready: go to IDLE.
- alu_ctrl is 0000 in IDLE and RESP. alu_a/alu_b keep their last latched values outside EXEC.
- Illegal op: alu_ctrl stays 0000 during EXEC (ALU yields 0), latency is 1, rsp_data=0, rsp_err=1.
- MUL result is the low 32 bits of the ALU product; no high word.
- Arithmetic is wrap-around mod 2^32. Without the configuration feature, rsp_err reflects only illegal ops.

## Timing
- Reset values:
  - state=IDLE, req_ready=1 on the cycle after reset.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - alu_a=0, alu_b=0, alu_ctrl=0000, counter=0.
- Handshake:
  - A request is accepted at edge t when req_valid&&req_ready.
  - Non-MUL: rsp_valid rises in cycle t+2.
  - MUL: rsp_valid rises in cycle t+MUL_CYCLES+1.
- A response is consumed at the edge where rsp_valid&&rsp_ready. req_ready returns the next cycle, so there is no back-to-back overlap. Maximum throughput is one op per latency+2 cycles.
- req_* are ignored while req_ready=0. rsp_ready is ignored while rsp_valid=0.
- MUL_CYCLES=1 gives MUL the same latency as other ops.
- reset mid-operation, in any state: the in-flight op is discarded with no response. The next cycle shows IDLE values and rsp_valid=0.
- Simultaneous reset and handshake: reset wins.

## Configuration
- ALU_SEQ_OVF_EN defined: for ADD and SUB, signed overflow is computed from the latched operands and the captured result, and ORed into rsp_err.
  - ADD overflow: operands have the same sign and the result sign differs.
  - SUB overflow: operands have different signs and the result sign differs from alu_a.
  - AND, OR and MUL never flag overflow.
- Undefined: no overflow logic; rsp_err = illegal-op only.

## Test plan
- ADD 5+7, rsp_ready=1 → alu_ctrl=0001 for exactly 1 cycle; rsp_valid in cycle t+2 with rsp_data=12, rsp_err=0.
- MUL 6*7, MUL_CYCLES=3 → alu_ctrl=0101 held 3 cycles with alu_a=6, alu_b=7; rsp_valid in cycle t+4 with rsp_data=42.
- SUB 3-5 with rsp_ready low for 5 cycles → rsp_data=0xFFFFFFFE stable, rsp_valid=1 and req_ready=0 throughout; IDLE the cycle after rsp_ready rises.
- req_op=7, a=1, b=1 → alu_ctrl=0000, rsp_data=0, rsp_err=1.
- ADD 0x7FFFFFFF+1 → rsp_data=0x80000000; rsp_err=1 with ALU_SEQ_OVF_EN, 0 without.
- MUL_CYCLES=3, reset asserted in the 2nd EXEC cycle → next cycle req_ready=1, rsp_valid=0, alu_ctrl=0000; no response is ever produced for that op.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
//
// Issue/capture front end for the execute-stage ALU. One operation is taken
// per request handshake. The operation is mapped to the ALU control code. The
// operands and the code are held on the ALU inputs for the operation's
// latency. The ALU result is then captured and offered on a response port.
//
// Optional feature (macro ALU_SEQ_OVF_EN):
//   defined   - signed overflow of ADD/SUB is ORed into rsp_err
//   undefined - rsp_err flags illegal opcodes only
//
// Parameters:
//   MUL_CYCLES  cycles the ALU inputs are held for MUL (1..15)
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_op/req_a/req_b     opcode (0 ADD,1 SUB,2 AND,3 OR,4 MUL,5-7 illegal),
//                          operands
//   alu_a/alu_b/alu_ctrl   drive the combinational ALU
//   alu_result             result from the ALU
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_err       captured result and error flag
//   dbg_state_o            current FSM state, for observation only
//
// Handshakes: a transfer happens on the rising edge where valid && ready are
// both high. The sender holds its payload stable while valid is high and
// ready is low. Inputs are ignored while the matching ready/valid is low.
// ---------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int unsigned MUL_CYCLES = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctrl,
   input  logic [31:0] alu_result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_e;

   localparam logic [3:0] MUL_LAT   = 4'(MUL_CYCLES);
   localparam logic [3:0] CTRL_ADD  = 4'b0001;
   localparam logic [3:0] CTRL_SUB  = 4'b0010;
   localparam logic [3:0] CTRL_AND  = 4'b0011;
   localparam logic [3:0] CTRL_OR   = 4'b0100;
   localparam logic [3:0] CTRL_MUL  = 4'b0101;
   localparam logic [3:0] CTRL_NONE = 4'b0000;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [3:0]  ctrl_q, ctrl_d;
   logic        perr_q, perr_d;
   logic [31:0] data_q, data_d;
   logic        err_q, err_d;

   logic [3:0]  op_ctrl;
   logic        ovf;

   // Opcode to ALU control code; illegal opcodes map to the idle code.
   always_comb begin
      op_ctrl = CTRL_NONE;
      case (req_op)
         3'd0:    op_ctrl = CTRL_ADD;
         3'd1:    op_ctrl = CTRL_SUB;
         3'd2:    op_ctrl = CTRL_AND;
         3'd3:    op_ctrl = CTRL_OR;
         3'd4:    op_ctrl = CTRL_MUL;
         default: op_ctrl = CTRL_NONE;
      endcase
   end

`ifdef ALU_SEQ_OVF_EN
   // Signed overflow from the held operands and the ALU result of this cycle.
   always_comb begin
      ovf = 1'b0;
      if (ctrl_q == CTRL_ADD)
         ovf = (a_q[31] == b_q[31]) && (alu_result[31] != a_q[31]);
      else if (ctrl_q == CTRL_SUB)
         ovf = (a_q[31] != b_q[31]) && (alu_result[31] != a_q[31]);
   end
`else
   assign ovf = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      ctrl_d  = ctrl_q;
      perr_d  = perr_q;
      data_d  = data_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               a_d     = req_a;
               b_d     = req_b;
               ctrl_d  = op_ctrl;
               cnt_d   = (req_op == 3'd4) ? MUL_LAT : 4'd1;
               perr_d  = (req_op > 3'd4);
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               // Illegal ops report zero regardless of what the ALU returns.
               data_d  = perr_q ? 32'd0 : alu_result;
               err_d   = perr_q | ovf;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         ctrl_q  <= CTRL_NONE;
         perr_q  <= 1'b0;
         data_q  <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctrl_q  <= ctrl_d;
         perr_q  <= perr_d;
         data_q  <= data_d;
         err_q   <= err_d;
      end
   end

   assign req_ready   = (state_q == S_IDLE);
   assign rsp_valid   = (state_q == S_RESP);
   assign alu_ctrl    = (state_q == S_EXEC) ? ctrl_q : CTRL_NONE;
   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign rsp_data    = data_q;
   assign rsp_err     = err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int MUL_CYCLES = 3;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  // scoreboard: expected response data and error flag, in issue order
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];

  alu_op_sequencer #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .dbg_state_o(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // combinational ALU the sequencer drives
  always_comb begin
    alu_result = 32'd0;
    case (alu_ctrl)
      4'b0001: alu_result = alu_a + alu_b;
      4'b0010: alu_result = alu_a - alu_b;
      4'b0011: alu_result = alu_a & alu_b;
      4'b0100: alu_result = alu_a | alu_b;
      4'b0101: alu_result = alu_a * alu_b;
      default: alu_result = 32'd0;
    endcase
  end

  // reference model ---------------------------------------------------------
  function automatic logic [31:0] ref_data(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint unsigned p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: begin p = longint'(a) * longint'(b); return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_err(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    logic e;
    e = (op > 3'd4);
`ifdef ALU_SEQ_OVF_EN
    if (op == 3'd0) s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 3'd1) s = longint'($signed(a)) - longint'($signed(b));
    else s = 0;
    if (s > 64'sd2147483647 || s < -64'sd2147483648) e = 1'b1;
`else
    if (a == b && a != a) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic logic [3:0] ref_ctrl(input logic [2:0] op);
    logic [3:0] tbl [0:7];
    tbl = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0};
    return tbl[op];
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    return (op == 3'd4) ? MUL_CYCLES : 1;
  endfunction

  // comparison --------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'd0);
  endtask

  // driver: issue one op, hold rsp_ready low for 'stall' RESP cycles, consume
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int stall);
    logic [31:0] ed;
    logic        ee;
    int          lat;
    lat = ref_lat(op);
    exp_q.push_back(ref_data(op, a, b));
    exp_err_q.push_back(ref_err(op, a, b));
    @(negedge clk);
    chk("pre_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
    @(negedge clk);
    // new requests while busy must be ignored
    req_op = 3'($urandom_range(0, 7)); req_a = $urandom; req_b = $urandom;
    for (int j = 0; j < lat; j++) begin
      chk("exec_req_ready", 32'(req_ready), 32'd0);
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("exec_alu_ctrl",  32'(alu_ctrl),  32'(ref_ctrl(op)));
      chk("exec_alu_a",     alu_a, a);
      chk("exec_alu_b",     alu_b, b);
      @(negedge clk);
    end
    ed = exp_q.pop_front();
    ee = exp_err_q.pop_front();
    for (int s = 0; s <= stall; s++) begin
      chk("resp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("resp_req_ready", 32'(req_ready), 32'd0);
      chk("resp_alu_ctrl",  32'(alu_ctrl),  32'd0);
      chk("resp_rsp_data",  rsp_data, ed);
      chk("resp_rsp_err",   32'(rsp_err), 32'(ee));
      if (s == stall) begin
        rsp_ready = 1'b1; req_valid = 1'b0;
      end
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    chk_idle("post");
    chk("post_alu_a", alu_a, a);
    chk("post_alu_b", alu_b, b);
  endtask

  // stimulus ----------------------------------------------------------------
  initial begin
    logic [31:0] edge_v [0:5];
    logic [31:0] ra, rb;
    checks = 0; errors = 0;
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    // reset state
    chk_idle("reset");
    chk("reset_alu_a",    alu_a, 32'd0);
    chk("reset_alu_b",    alu_b, 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_rsp_err",  32'(rsp_err), 32'd0);

    // directed cases
    run_op(3'd0, 32'd5, 32'd7, 0);
    run_op(3'd4, 32'd6, 32'd7, 0);
    run_op(3'd1, 32'd3, 32'd5, 5);
    run_op(3'd7, 32'd1, 32'd1, 1);
    run_op(3'd0, 32'h7FFF_FFFF, 32'd1, 0);
    run_op(3'd1, 32'h8000_0000, 32'd1, 0);
    run_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    run_op(3'd3, 32'hF000_0000, 32'h0000_000F, 2);
    run_op(3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    chk("add_5_7_const", ref_data(3'd0, 32'd5, 32'd7), 32'd12);

    // reset in the 2nd EXEC cycle of a MUL
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_a = 32'd9; req_b = 32'd9;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mulrst_exec1_ctrl", 32'(alu_ctrl), 32'd5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("mulrst");
    chk("mulrst_alu_a", alu_a, 32'd0);
    rsp_ready = 1'b1;
    for (int k = 0; k < MUL_CYCLES + 3; k++) begin
      @(negedge clk);
      chk("mulrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    rsp_ready = 1'b0;

    // reset wins over a simultaneous request handshake
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd11; req_b = 32'd22; reset = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b0;
    chk_idle("rst_vs_req");
    chk("rst_vs_req_alu_a", alu_a, 32'd0);
    @(negedge clk);
    chk("rst_vs_req_still_idle", 32'(req_ready), 32'd1);

    // randomized ops against the reference model
    edge_v = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0001_0000};
    for (int n = 0; n < 30; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
      run_op(3'($urandom_range(0, 7)), ra, rb, $urandom_range(0, 3));
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
